// File: rtl/alu_seq_pkg.sv
// Shared definitions for the UART-to-ALU command sequencer: FSM state codes,
// ALU opcodes and the bit positions used in the returned flags byte.
package alu_seq_pkg;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_IDLE     = 4'd0;
  localparam seq_state_t ST_LOAD_A   = 4'd1;
  localparam seq_state_t ST_WAIT_B   = 4'd2;
  localparam seq_state_t ST_LOAD_B   = 4'd3;
  localparam seq_state_t ST_WAIT_OP  = 4'd4;
  localparam seq_state_t ST_LOAD_OP  = 4'd5;
  localparam seq_state_t ST_EXEC     = 4'd6;
  localparam seq_state_t ST_TX_RES   = 4'd7;
  localparam seq_state_t ST_WAIT_RES = 4'd8;
  localparam seq_state_t ST_TX_FLG   = 4'd9;
  localparam seq_state_t ST_WAIT_FLG = 4'd10;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam int FLG_ZERO = 0;
  localparam int FLG_OVF  = 1;

  // Wide enough for the inter-byte timeout at any realistic baud rate.
  localparam int NB_CNT = 32;

endpackage

// File: rtl/alu_seq_timer.sv
// Loadable down-counter that saturates at zero; reused for the EXEC latency
// count and for the inter-byte timeout.
module alu_seq_timer
  import alu_seq_pkg::*;
#(
  parameter int NB_W = NB_CNT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic            i_en,
  input  logic [NB_W-1:0] i_load_val,
  output logic            o_expired
);

  logic [NB_W-1:0] cnt_q;
  logic [NB_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - NB_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/alu_uart_seq.sv
// Command sequencer: three UART bytes (A, B, OP) drive the ALU load enables,
// then the ALU result and flags are returned as a two-byte UART response.
module alu_uart_seq
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int ALU_LAT     = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_zero,
  input  logic               i_alu_overflow,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_en_A,
  output logic               o_en_B,
  output logic               o_en_OP,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_drop,
  output logic               o_timeout
);

  localparam logic [NB_CNT-1:0] EXEC_LOAD = NB_CNT'(ALU_LAT - 1);
  localparam logic [NB_CNT-1:0] TO_LOAD   = (TIMEOUT_CYC > 0) ? NB_CNT'(TIMEOUT_CYC - 1) : '0;
  localparam bit                TO_EN     = (TIMEOUT_CYC > 0);

  seq_state_t         state_q, state_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic [NB_DATA-1:0] flg_q, flg_d;
  logic [NB_DATA-1:0] flg_cap;
  logic               en_a_q, en_a_d;
  logic               en_b_q, en_b_d;
  logic               en_op_q, en_op_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic               timeout_q, timeout_d;

  logic               tmr_clear;
  logic               tmr_en;
  logic [NB_CNT-1:0]  tmr_load;
  logic               tmr_expired;

  alu_seq_timer #(
    .NB_W (NB_CNT)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (tmr_clear),
    .i_en       (tmr_en),
    .i_load_val (tmr_load),
    .o_expired  (tmr_expired)
  );

  always_comb begin
    flg_cap           = '0;
    flg_cap[FLG_ZERO] = i_alu_zero;
    flg_cap[FLG_OVF]  = i_alu_overflow;
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    tx_data_d = tx_data_q;
    flg_d     = flg_q;
    timeout_d = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    tmr_load  = TO_LOAD;

    // Outputs are registered from the next state, so the byte lands in o_data
    // on the same edge that enters the matching LOAD state.
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          state_d = ST_LOAD_A;
          data_d  = i_rx_data;
        end
      end
      ST_LOAD_A: begin
        state_d   = ST_WAIT_B;
        tmr_clear = 1'b1;
      end
      ST_WAIT_B: begin
        tmr_en = 1'b1;
        if (i_rx_done) begin
          state_d = ST_LOAD_B;
          data_d  = i_rx_data;
        end else if (TO_EN && tmr_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_LOAD_B: begin
        state_d   = ST_WAIT_OP;
        tmr_clear = 1'b1;
      end
      ST_WAIT_OP: begin
        tmr_en = 1'b1;
        if (i_rx_done) begin
          state_d = ST_LOAD_OP;
          data_d  = {{(NB_DATA-NB_OP){1'b0}}, i_rx_data[NB_OP-1:0]};
        end else if (TO_EN && tmr_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_LOAD_OP: begin
        state_d   = ST_EXEC;
        tmr_clear = 1'b1;
        tmr_load  = EXEC_LOAD;
      end
      ST_EXEC: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d   = ST_TX_RES;
          tx_data_d = i_alu_result;
          flg_d     = flg_cap;
        end
      end
      ST_TX_RES: begin
        state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (i_tx_done) begin
          state_d   = ST_TX_FLG;
          tx_data_d = flg_q;
        end
      end
      ST_TX_FLG: begin
        state_d = ST_WAIT_FLG;
      end
      ST_WAIT_FLG: begin
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    drop_d     = i_rx_done && !(state_q inside {ST_IDLE, ST_WAIT_B, ST_WAIT_OP});
    en_a_d     = (state_d == ST_LOAD_A);
    en_b_d     = (state_d == ST_LOAD_B);
    en_op_d    = (state_d == ST_LOAD_OP);
    tx_start_d = (state_d == ST_TX_RES) || (state_d == ST_TX_FLG);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      tx_data_q  <= '0;
      flg_q      <= '0;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      en_op_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      flg_q      <= flg_d;
      en_a_q     <= en_a_d;
      en_b_q     <= en_b_d;
      en_op_q    <= en_op_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_data     = data_q;
  assign o_en_A     = en_a_q;
  assign o_en_B     = en_b_q;
  assign o_en_OP    = en_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_drop     = drop_q;
  assign o_timeout  = timeout_q;

endmodule
